// File: rtl/uart_rx_conditioner_if.sv
// Pad-side bundle of the UART RX conditioner: raw pad level in, conditioned level and status out.
interface uart_rx_conditioner_if;
    logic       io_rxd_pin;
    logic       io_rxd;
    logic       io_break;
    logic       io_activity;
    logic [7:0] io_glitchCount;

    modport master (
        output io_rxd_pin,
        input  io_rxd,
        input  io_break,
        input  io_activity,
        input  io_glitchCount
    );

    modport slave (
        input  io_rxd_pin,
        output io_rxd,
        output io_break,
        output io_activity,
        output io_glitchCount
    );
endinterface

// File: rtl/uart_rx_conditioner.sv
// UART RX pad conditioner: synchroniser, stability filter, break detector and activity stretcher.
// Define UART_RX_GLITCH_COUNT_EN to build the saturating glitch counter; otherwise it reads as zero.
module uart_rx_conditioner #(
    parameter int SYNC_STAGES  = 2,
    parameter int FILTER_LEN   = 4,
    parameter int BREAK_CYCLES = 1200000,
    parameter int ACT_STRETCH  = 600000
) (
    input  logic                   io_mainClk,
    input  logic                   io_reset,
    uart_rx_conditioner_if.slave   bus
);

    localparam logic [3:0]  FILT_LAST  = 4'(FILTER_LEN - 1);
    localparam logic [23:0] BREAK_TC   = 24'(BREAK_CYCLES);
    localparam logic [23:0] STRETCH_LD = 24'(ACT_STRETCH);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [3:0]             fcnt;
    logic                   rxd_q;
    logic                   rxd_d;
    logic [23:0]            bcnt;
    logic [23:0]            scnt;
    logic                   brk_q;
    logic                   act_q;

    logic                   rxd_next;
    logic                   brk_next;
    logic                   fall;
    logic [23:0]            bcnt_next;
    logic [23:0]            scnt_next;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        rxd_next = rxd_q;
        if (s != rxd_q && fcnt == FILT_LAST)
            rxd_next = s;

        // Break state clears on the very edge the filtered line returns high.
        bcnt_next = 24'd0;
        if (!rxd_q && !rxd_next)
            bcnt_next = (bcnt == BREAK_TC) ? bcnt : bcnt + 24'd1;
        brk_next = !rxd_next && (bcnt == BREAK_TC);

        fall = rxd_d & ~rxd_q;
        scnt_next = 24'd0;
        if (fall)
            scnt_next = STRETCH_LD;
        else if (scnt != 24'd0)
            scnt_next = scnt - 24'd1;
    end

    always_ff @(posedge io_mainClk) begin
        if (io_reset) begin
            sync_q <= '1;
            fcnt   <= 4'd0;
            rxd_q  <= 1'b1;
            rxd_d  <= 1'b1;
            bcnt   <= 24'd0;
            brk_q  <= 1'b0;
            scnt   <= 24'd0;
            act_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.io_rxd_pin};
            if (s == rxd_q || fcnt == FILT_LAST)
                fcnt <= 4'd0;
            else
                fcnt <= fcnt + 4'd1;
            rxd_q  <= rxd_next;
            rxd_d  <= rxd_q;
            bcnt   <= bcnt_next;
            brk_q  <= brk_next;
            scnt   <= scnt_next;
            act_q  <= (scnt_next != 24'd0) && !brk_next;
        end
    end

`ifdef UART_RX_GLITCH_COUNT_EN
    logic [7:0] gcnt;

    // A disagreement that ended before acceptance is a rejected glitch.
    always_ff @(posedge io_mainClk) begin
        if (io_reset)
            gcnt <= 8'd0;
        else if (fcnt != 4'd0 && s == rxd_q && gcnt != 8'hFF)
            gcnt <= gcnt + 8'd1;
    end

    assign bus.io_glitchCount = gcnt;
`else
    assign bus.io_glitchCount = 8'h00;
`endif

    assign bus.io_rxd      = rxd_q;
    assign bus.io_break    = brk_q;
    assign bus.io_activity = act_q;

endmodule
